// File: rtl/core_reg_file_sb_if.sv
// Decode/writeback side of the scoreboarded register file.
// The master drives read and write requests; the slave returns read data and busy status.
interface core_reg_file_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 1
);
    localparam int AW = $clog2(NREG);

    logic                 stall_n;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;
    logic [NWR-1:0]       wr_clr;
    logic                 iss_en;
    logic [AW-1:0]        iss_addr;
    logic [AW:0]          busy_cnt;

    modport master (
        output stall_n, rd_addr, wr_en, wr_addr, wr_data, wr_clr, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  stall_n, rd_addr, wr_en, wr_addr, wr_data, wr_clr, iss_en, iss_addr,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/core_reg_file_sb.sv
// Multi-ported integer register file with a hard-wired zero register, optional
// write-to-read bypass and a pending-write scoreboard for RAW hazard detection.
module core_reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    core_reg_file_sb_if.slave  bus
);
    localparam int AW = $clog2(NREG);
    localparam int CW = AW + 1;

    logic [XLEN-1:0]  regs [NREG];
    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  busy_next;
    logic [NREG-1:0]  clr_vec;
    logic [CW-1:0]    busy_cnt_q;
    logic [CW-1:0]    cnt_next;

    logic [NRD*XLEN-1:0] rd_data_c;
    logic [NRD-1:0]      rd_busy_c;
    logic [AW-1:0]       ra;
    logic [XLEN-1:0]     rdat;

    // A simultaneous issue to the same register wins over a retiring write.
    always_comb begin
        clr_vec = '0;
        for (int j = 0; j < NWR; j++) begin
            if (bus.wr_en[j] && bus.wr_clr[j]) begin
                clr_vec[bus.wr_addr[j*AW +: AW]] = 1'b1;
            end
        end
        clr_vec[0] = 1'b0;

        busy_next = busy;
        if (bus.stall_n) begin
            busy_next = busy & ~clr_vec;
            if (bus.iss_en) begin
                busy_next[bus.iss_addr] = 1'b1;
            end
            busy_next[0] = 1'b0;
        end

        cnt_next = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_next = cnt_next + CW'(busy_next[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (bus.stall_n) begin
            for (int j = 0; j < NWR; j++) begin
                if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] != '0)) begin
                    regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy       <= busy_next;
            busy_cnt_q <= cnt_next;
        end
    end

    // Forwarded data ignores stall so the consumer always sees the value being written.
    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        ra        = '0;
        rdat      = '0;
        for (int i = 0; i < NRD; i++) begin
            ra   = bus.rd_addr[i*AW +: AW];
            rdat = regs[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == ra)) begin
                        rdat = bus.wr_data[j*XLEN +: XLEN];
                    end
                end
            end
            if ((ra == '0) || !rst_n) begin
                rdat = '0;
            end
            rd_data_c[i*XLEN +: XLEN] = rdat;
            rd_busy_c[i] = rst_n && (ra != '0) && busy[ra]
                           && !((BYPASS != 0) && bus.stall_n && clr_vec[ra]);
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_core_reg_file_sb.sv
// Randomised and directed bench for core_reg_file_sb with a register/scoreboard
// reference model checked on every falling clock edge.
module tb_core_reg_file_sb;
    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int NRD    = 2;
    localparam int NWR    = 2;
    localparam int BYPASS = 1;
    localparam int AW     = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    core_reg_file_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

    core_reg_file_sb #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(BYPASS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];

    // Architectural model: registers as a plain array, busy as one flag per register.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else if (bus.stall_n) begin
            for (int j = 0; j < NWR; j++) begin
                if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != 0)
                    m_regs[bus.wr_addr[j*AW +: AW]] = bus.wr_data[j*XLEN +: XLEN];
            end
            for (int r = 1; r < NREG; r++) begin
                bit set_r;
                bit clr_r;
                set_r = bus.iss_en && (int'(bus.iss_addr) == r);
                clr_r = 1'b0;
                for (int j = 0; j < NWR; j++) begin
                    if (bus.wr_en[j] && bus.wr_clr[j] && int'(bus.wr_addr[j*AW +: AW]) == r)
                        clr_r = 1'b1;
                end
                if (set_r)      m_busy[r] = 1'b1;
                else if (clr_r) m_busy[r] = 1'b0;
            end
        end
    end

    function automatic logic [XLEN-1:0] exp_rd_data(int i);
        logic [AW-1:0]   a;
        logic [XLEN-1:0] v;
        a = bus.rd_addr[i*AW +: AW];
        if (!rst_n || a == 0) return '0;
        v = m_regs[a];
        for (int j = 0; j < NWR; j++) begin
            if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == a) v = bus.wr_data[j*XLEN +: XLEN];
        end
        return v;
    endfunction

    function automatic logic exp_rd_busy(int i);
        logic [AW-1:0] a;
        a = bus.rd_addr[i*AW +: AW];
        if (!rst_n || a == 0) return 1'b0;
        if (bus.stall_n) begin
            for (int j = 0; j < NWR; j++) begin
                if (bus.wr_en[j] && bus.wr_clr[j] && bus.wr_addr[j*AW +: AW] == a) return 1'b0;
            end
        end
        return m_busy[a];
    endfunction

    function automatic logic [31:0] exp_busy_cnt();
        int n;
        n = 0;
        for (int r = 0; r < NREG; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NRD; i++) begin
            checkOutput($sformatf("model rd_data[%0d]", i), bus.rd_data[i*XLEN +: XLEN], exp_rd_data(i));
            checkOutput($sformatf("model rd_busy[%0d]", i), 32'(bus.rd_busy[i]), 32'(exp_rd_busy(i)));
        end
        checkOutput("model busy_cnt", 32'(bus.busy_cnt), exp_busy_cnt());
    end

    task automatic applyStimulus(
        input logic            st,
        input logic [1:0]      we,
        input logic [AW-1:0]   wa0,
        input logic [XLEN-1:0] wd0,
        input logic [AW-1:0]   wa1,
        input logic [XLEN-1:0] wd1,
        input logic [1:0]      wc,
        input logic            ie,
        input logic [AW-1:0]   ia,
        input logic [AW-1:0]   r0,
        input logic [AW-1:0]   r1
    );
        @(posedge clk);
        #1;
        bus.stall_n  = st;
        bus.wr_en    = we;
        bus.wr_addr  = {wa1, wa0};
        bus.wr_data  = {wd1, wd0};
        bus.wr_clr   = wc;
        bus.iss_en   = ie;
        bus.iss_addr = ia;
        bus.rd_addr  = {r1, r0};
        #1;
    endtask

    task automatic readOnly(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        applyStimulus(1'b1, 2'b00, 5'd0, '0, 5'd0, '0, 2'b00, 1'b0, 5'd0, r0, r1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.stall_n  = 1'b1;
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.wr_clr   = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        bus.rd_addr  = {5'd2, 5'd1};
        #2;
        checkOutput("reset busy_cnt", 32'(bus.busy_cnt), 32'd0);
        checkOutput("reset rd_data0", bus.rd_data[31:0], 32'd0);
        checkOutput("reset rd_busy", 32'(bus.rd_busy), 32'd0);
        #10 rst_n = 1'b1;

        for (int a = 1; a < NREG; a++) begin
            readOnly(AW'(a), AW'(NREG - a));
            checkOutput("post-reset rd_data0", bus.rd_data[31:0], 32'd0);
            checkOutput("post-reset rd_data1", bus.rd_data[63:32], 32'd0);
            checkOutput("post-reset rd_busy", 32'(bus.rd_busy), 32'd0);
        end

        applyStimulus(1'b1, 2'b01, 5'd0, 32'hDEADBEEF, 5'd0, '0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0);
        checkOutput("x0 no bypass", bus.rd_data[31:0], 32'd0);
        readOnly(5'd0, 5'd0);
        checkOutput("x0 stays zero", bus.rd_data[31:0], 32'd0);

        applyStimulus(1'b1, 2'b01, 5'd5, 32'h12345678, 5'd0, '0, 2'b00, 1'b0, 5'd0, 5'd1, 5'd1);
        readOnly(5'd5, 5'd5);
        checkOutput("x5 port0", bus.rd_data[31:0], 32'h12345678);
        checkOutput("x5 port1", bus.rd_data[63:32], 32'h12345678);
        applyStimulus(1'b1, 2'b01, 5'd6, 32'hA5A5A5A5, 5'd0, '0, 2'b00, 1'b0, 5'd0, 5'd6, 5'd0);
        checkOutput("x6 bypass", bus.rd_data[31:0], 32'hA5A5A5A5);

        applyStimulus(1'b0, 2'b01, 5'd7, 32'h1, 5'd0, '0, 2'b00, 1'b1, 5'd8, 5'd7, 5'd8);
        checkOutput("stall bypass x7", bus.rd_data[31:0], 32'h1);
        checkOutput("stall busy x8", 32'(bus.rd_busy[1]), 32'd0);
        readOnly(5'd7, 5'd8);
        checkOutput("stall x7 unwritten", bus.rd_data[31:0], 32'd0);
        checkOutput("stall x8 not busy", 32'(bus.rd_busy[1]), 32'd0);
        checkOutput("stall busy_cnt", 32'(bus.busy_cnt), 32'd0);

        applyStimulus(1'b1, 2'b00, 5'd0, '0, 5'd0, '0, 2'b00, 1'b1, 5'd3, 5'd3, 5'd0);
        readOnly(5'd3, 5'd0);
        checkOutput("issue x3 busy", 32'(bus.rd_busy[0]), 32'd1);
        checkOutput("issue busy_cnt", 32'(bus.busy_cnt), 32'd1);
        applyStimulus(1'b1, 2'b01, 5'd3, 32'h55, 5'd0, '0, 2'b01, 1'b0, 5'd0, 5'd3, 5'd0);
        checkOutput("retire x3 busy", 32'(bus.rd_busy[0]), 32'd0);
        checkOutput("retire x3 data", bus.rd_data[31:0], 32'h55);
        checkOutput("retire cnt before edge", 32'(bus.busy_cnt), 32'd1);
        readOnly(5'd3, 5'd0);
        checkOutput("retire busy_cnt", 32'(bus.busy_cnt), 32'd0);
        checkOutput("retire x3 stored", bus.rd_data[31:0], 32'h55);

        applyStimulus(1'b1, 2'b01, 5'd4, 32'h44, 5'd0, '0, 2'b01, 1'b1, 5'd4, 5'd4, 5'd0);
        readOnly(5'd4, 5'd0);
        checkOutput("set+clr x4 busy", 32'(bus.rd_busy[0]), 32'd1);
        checkOutput("set+clr x4 data", bus.rd_data[31:0], 32'h44);
        checkOutput("set+clr busy_cnt", 32'(bus.busy_cnt), 32'd1);

        applyStimulus(1'b1, 2'b11, 5'd9, 32'h11, 5'd9, 32'h22, 2'b00, 1'b0, 5'd0, 5'd9, 5'd0);
        checkOutput("dual bypass x9", bus.rd_data[31:0], 32'h22);
        readOnly(5'd9, 5'd0);
        checkOutput("dual stored x9", bus.rd_data[31:0], 32'h22);

        applyStimulus(1'b1, 2'b00, 5'd0, '0, 5'd0, '0, 2'b00, 1'b1, 5'd10, 5'd9, 5'd4);
        applyStimulus(1'b1, 2'b00, 5'd0, '0, 5'd0, '0, 2'b00, 1'b1, 5'd11, 5'd9, 5'd4);
        readOnly(5'd9, 5'd4);
        checkOutput("pre-reset busy_cnt", 32'(bus.busy_cnt), 32'd3);
        checkOutput("pre-reset x4 busy", 32'(bus.rd_busy[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset busy_cnt", 32'(bus.busy_cnt), 32'd0);
        checkOutput("async reset x9", bus.rd_data[31:0], 32'd0);
        checkOutput("async reset busy", 32'(bus.rd_busy), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        readOnly(5'd9, 5'd4);
        checkOutput("after reset x9", bus.rd_data[31:0], 32'd0);

        for (int n = 0; n < 600; n++) begin
            applyStimulus(
                $urandom_range(0, 9) != 0,
                2'($urandom_range(0, 3)),
                5'($urandom_range(0, 15)), $urandom,
                5'($urandom_range(0, 15)), $urandom,
                2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)),
                5'($urandom_range(0, 15)),
                5'($urandom_range(0, 15)),
                5'($urandom_range(0, 31))
            );
        end

        readOnly(5'd0, 5'd0);
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
